// File: rtl/param_router_pkg.sv
// Shared types, default parameters and flit-layout helpers for the wormhole router.
// A flit is stored as {tail, dest, data}, with data in the low bits.
package param_router_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_DATA_W     = 32;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int flit_dest_lo(input int data_w);
    return data_w;
  endfunction

  function automatic int flit_tail_bit(input int data_w, input int dest_w);
    return data_w + dest_w;
  endfunction

  function automatic int flit_width(input int data_w, input int dest_w);
    return data_w + dest_w + 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/param_wormhole_router_arbiter.sv
// Per-output round-robin arbiter that holds its grant on one input from the
// first granted flit until that input's tail flit is accepted downstream.
module rr_wormhole_arbiter
  import param_router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] tail_i,
  input  logic                 ready_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     winner_o,
  output arb_state_e           state_o
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] scan_idx, pick;
  logic             found;
  int               scan;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan     = 0;
    scan_idx = '0;
    // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      scan_idx = IDX_W'(scan);
      if (!found && req_i[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end

    grant_o  = '0;
    valid_o  = 1'b0;
    winner_o = pick;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;

    if (state_q == ARB_LOCKED) begin
      winner_o = owner_q;
      // An empty owner FIFO yields a bubble but the lock is kept.
      if (req_i[owner_q]) begin
        grant_o[owner_q] = 1'b1;
        valid_o          = 1'b1;
        if (ready_i && tail_i[owner_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDX_W'(wrap_inc(int'(owner_q), NUM_PORTS));
        end
      end
    end else if (found) begin
      grant_o[pick] = 1'b1;
      valid_o       = 1'b1;
      if (ready_i && tail_i[pick]) begin
        rr_ptr_d = IDX_W'(wrap_inc(int'(pick), NUM_PORTS));
      end else begin
        state_d = ARB_LOCKED;
        owner_d = pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/param_wormhole_router.sv
// NxN input-buffered wormhole router: one FIFO per input, one locking
// round-robin arbiter per output, valid/ready output handshake.
// Handshake: a flit moves on output j in a cycle where out_valid[j] && out_ready[j];
// out_valid holds with stable payload until then. Inputs write when in_valid && !fifo_full.
module param_wormhole_router
  import param_router_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEST_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS-1:0]          in_tail,
  input  logic [NUM_PORTS*DEST_W-1:0]   in_dest,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          fifo_full,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS-1:0]          out_tail,
  output logic [NUM_PORTS*DEST_W-1:0]   out_src,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS-1:0]          drop_err
);

  localparam int FLIT_W = flit_width(DATA_W, DEST_W);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [NUM_PORTS-1:0] fifo_empty, pop, drop, head_tail;
  logic [DEST_W-1:0]    head_dest [NUM_PORTS];
  logic [DATA_W-1:0]    head_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] req       [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant     [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_valid;
  logic [DEST_W-1:0]    arb_winner [NUM_PORTS];
  arb_state_e           arb_state  [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [FLIT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FLIT_W-1:0] head;
    logic              wr_en;

    // Full is the registered count, so a same-cycle pop never frees a slot early.
    assign wr_en = in_valid[i] && !fifo_full[i];

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
        mem_d[wr_ptr_q] = {in_tail[i],
                           in_dest[slice_lo(i, DEST_W) +: DEST_W],
                           in_data[slice_lo(i, DATA_W) +: DATA_W]};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop[i]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !pop[i])      count_d = count_q + CNT_W'(1);
      else if (!wr_en && pop[i]) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        mem_q    <= '{default: '0};
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    assign head          = mem_q[rd_ptr_q];
    assign fifo_full[i]  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty[i] = (count_q == '0);
    assign head_tail[i]  = head[flit_tail_bit(DATA_W, DEST_W)];
    assign head_dest[i]  = head[flit_dest_lo(DATA_W) +: DEST_W];
    assign head_data[i]  = head[DATA_W-1:0];
    // Out-of-range heads only exist when NUM_PORTS is not a power of two.
    assign drop[i]       = !fifo_empty[i] && (int'(head_dest[i]) >= NUM_PORTS);
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) req[j] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!fifo_empty[i] && head_dest[i] == DEST_W'(j)) req[j][i] = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_wormhole_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (DEST_W)
    ) u_arb (
      .clk      (clk),
      .rst_b    (rst_b),
      .req_i    (req[j]),
      .tail_i   (head_tail),
      .ready_i  (out_ready[j]),
      .grant_o  (grant[j]),
      .valid_o  (arb_valid[j]),
      .winner_o (arb_winner[j]),
      .state_o  (arb_state[j])
    );
  end

  always_comb begin
    pop = drop;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[j][i] && out_ready[j]) pop[i] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_tail  = '0;
    out_src   = '0;
    out_data  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (arb_valid[j]) begin
        out_valid[j]                                = 1'b1;
        out_tail[j]                                 = head_tail[arb_winner[j]];
        out_src[slice_lo(j, DEST_W) +: DEST_W]      = arb_winner[j];
        out_data[slice_lo(j, DATA_W) +: DATA_W]     = head_data[arb_winner[j]];
      end
    end
  end

  assign drop_err = drop;

  // Every flit of a packet must target the output its owner has locked.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (arb_state[j] == ARB_LOCKED && !fifo_empty[arb_winner[j]])
          assert (head_dest[arb_winner[j]] == DEST_W'(j));
      end
    end
  end

endmodule

// File: tb/tb_param_wormhole_router.sv
// Directed bench for param_wormhole_router: per-output expected-flit queues
// filled at injection and drained by a negedge monitor, plus a 3-port instance.
module tb_param_wormhole_router;

  localparam int NP  = 4;
  localparam int DW  = 32;
  localparam int DSW = 2;
  localparam int EW  = DSW + 1 + DW;

  logic clk = 1'b0;
  logic rst_b;

  logic [NP-1:0]     in_valid, in_tail, fifo_full, out_valid, out_tail, out_ready, drop_err;
  logic [NP*DSW-1:0] in_dest, out_src;
  logic [NP*DW-1:0]  in_data, out_data;

  logic [2:0]        in_valid3, in_tail3, fifo_full3, out_valid3, out_tail3, out_ready3, drop_err3;
  logic [3*DSW-1:0]  in_dest3, out_src3;
  logic [3*DW-1:0]   in_data3, out_data3;

  logic [EW-1:0] exp_q [NP][$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  param_wormhole_router #(.NUM_PORTS(NP), .FIFO_DEPTH(4), .DATA_W(DW)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_tail(in_tail), .in_dest(in_dest), .in_data(in_data),
    .fifo_full(fifo_full),
    .out_valid(out_valid), .out_tail(out_tail), .out_src(out_src), .out_data(out_data),
    .out_ready(out_ready), .drop_err(drop_err)
  );

  param_wormhole_router #(.NUM_PORTS(3), .FIFO_DEPTH(4), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid3), .in_tail(in_tail3), .in_dest(in_dest3), .in_data(in_data3),
    .fifo_full(fifo_full3),
    .out_valid(out_valid3), .out_tail(out_tail3), .out_src(out_src3), .out_data(out_data3),
    .out_ready(out_ready3), .drop_err(drop_err3)
  );

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [DSW-1:0] dest,
                       input logic tail, input logic [DW-1:0] data);
    in_valid[i]         = v;
    in_tail[i]          = tail;
    in_dest[i*DSW+:DSW] = dest;
    in_data[i*DW+:DW]   = data;
  endtask

  task automatic expect_flit(input int j, input int src, input logic tail, input logic [DW-1:0] data);
    exp_q[j].push_back({DSW'(src), tail, data});
  endtask

  task automatic send(input int i, input int dest, input logic tail, input logic [DW-1:0] data);
    drive(i, 1'b1, DSW'(dest), tail, data);
    expect_flit(dest, i, tail, data);
  endtask

  function automatic int pending();
    int s = 0;
    for (int j = 0; j < NP; j++) s += exp_q[j].size();
    return s;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 64'(pending()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_b) begin
      for (int j = 0; j < NP; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          check("sb_flit_expected", 64'(exp_q[j].size() != 0), 64'd1);
          if (exp_q[j].size() != 0)
            check($sformatf("sb_out%0d_flit", j),
                  64'({out_src[j*DSW+:DSW], out_tail[j], out_data[j*DW+:DW]}),
                  64'(exp_q[j].pop_front()));
        end else if (!out_valid[j]) begin
          check($sformatf("idle_out%0d_zero", j),
                64'({out_src[j*DSW+:DSW], out_tail[j], out_data[j*DW+:DW]}), 64'd0);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DW-1:0] d0, d1, d2, d3;

    rst_b     = 1'b0;
    in_valid  = '0; in_tail  = '0; in_dest  = '0; in_data  = '0; out_ready  = '0;
    in_valid3 = '0; in_tail3 = '0; in_dest3 = '0; in_data3 = '0; out_ready3 = '1;
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    check("reset_fifo_full", 64'(fifo_full), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_drop_err",  64'(drop_err),  64'd0);
    check("reset_out_data",  64'(out_data[63:0]), 64'd0);

    // 1. Move out1's rr_ptr off zero, then reset with flits buffered mid-packet.
    out_ready = '1;
    send(2, 1, 1'b1, $urandom());
    tick();
    in_valid = '0;
    drain(10);
    out_ready = '0;
    drive(0, 1'b1, 2'd1, 1'b0, $urandom());
    drive(2, 1'b1, 2'd1, 1'b0, $urandom());
    tick();
    in_valid = '0;
    tick();
    check("prereset_out1_valid", 64'(out_valid[1]), 64'd1);
    #2 rst_b = 1'b0;
    #1;
    check("midreset_fifo_full", 64'(fifo_full), 64'd0);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_drop_err",  64'(drop_err),  64'd0);
    tick();
    rst_b = 1'b1;
    out_ready = '1;
    d0 = $urandom();
    d1 = $urandom();
    drive(0, 1'b1, 2'd1, 1'b1, d0);
    drive(3, 1'b1, 2'd1, 1'b1, d1);
    expect_flit(1, 0, 1'b1, d0);
    expect_flit(1, 3, 1'b1, d1);
    tick();
    in_valid = '0;
    drain(10);

    // 2. Single-flit packets from all inputs to out1, two rounds.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NP; i++) send(i, 1, 1'b1, $urandom());
      tick();
      if (r == 0) begin
        check("single_latency_valid", 64'(out_valid[1]), 64'd1);
        check("single_first_src", 64'(out_src[1*DSW+:DSW]), 64'd0);
      end
    end
    in_valid = '0;
    drain(20);

    // 3. Three-flit packet from input 1 must not interleave with input 3's flit.
    d0 = $urandom(); d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
    drive(1, 1'b1, 2'd0, 1'b0, d0);
    drive(3, 1'b1, 2'd0, 1'b1, d3);
    expect_flit(0, 1, 1'b0, d0);
    tick();
    in_valid[3] = 1'b0;
    send(1, 0, 1'b0, d1);
    tick();
    send(1, 0, 1'b1, d2);
    expect_flit(0, 3, 1'b1, d3);
    tick();
    in_valid = '0;
    drain(20);

    // 4. Backpressure on out2 while input 0 streams six flits into a depth-4 FIFO.
    out_ready = 4'b1011;
    d0 = $urandom();
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, 2'd2, (k == 3), d0 + DW'(k));
      if (k < 4) expect_flit(2, 0, (k == 3), d0 + DW'(k));
      tick();
      check("bp_out2_valid", 64'(out_valid[2]), 64'd1);
      check("bp_out2_data_stable", 64'(out_data[2*DW+:DW]), 64'(d0));
      check("bp_fifo0_full", 64'(fifo_full[0]), 64'(k >= 3));
    end
    in_valid = '0;
    out_ready = '1;
    drain(20);
    check("bp_fifo0_unfull", 64'(fifo_full[0]), 64'd0);

    // 5. Parallel transfers, then a mid-packet bubble with a competing requester.
    d0 = $urandom(); d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
    send(0, 3, 1'b0, d0);
    send(1, 2, 1'b1, d1);
    tick();
    check("parallel_valid_3_2", 64'(out_valid[3:2]), 64'd3);
    in_valid = '0;
    drive(2, 1'b1, 2'd3, 1'b1, d2);
    tick();
    in_valid = '0;
    check("bubble_out3_low", 64'(out_valid[3]), 64'd0);
    tick();
    check("bubble_out3_still_low", 64'(out_valid[3]), 64'd0);
    send(0, 3, 1'b1, d3);
    expect_flit(3, 2, 1'b1, d2);
    tick();
    in_valid = '0;
    drain(20);

    // 6. Three-port instance: destination 3 is out of range and gets dropped.
    d0 = $urandom(); d1 = $urandom();
    in_valid3 = 3'b100; in_tail3[2] = 1'b1; in_dest3[2*DSW+:DSW] = 2'd3; in_data3[2*DW+:DW] = d0;
    tick();
    check("drop_err_pulse", 64'(drop_err3), 64'h4);
    check("drop_no_out_valid", 64'(out_valid3), 64'd0);
    in_dest3[2*DSW+:DSW] = 2'd1; in_data3[2*DW+:DW] = d1;
    tick();
    in_valid3 = '0;
    check("drop_err_cleared", 64'(drop_err3), 64'd0);
    check("after_drop_valid", 64'(out_valid3), 64'h2);
    check("after_drop_src",   64'(out_src3[1*DSW+:DSW]), 64'd2);
    check("after_drop_data",  64'(out_data3[1*DW+:DW]), 64'(d1));
    check("after_drop_tail",  64'(out_tail3), 64'h2);
    tick();
    check("after_drop_drained", 64'(out_valid3), 64'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
